quad_enc_gen: RTL and testbench
===============================

Name: quad_enc_gen

Overview:
- Parametrised quadrature encoder emulator; next generation of the incremental A/B/Z signal generator.
- Adds: configurable counts-per-revolution with automatic index (Z) at position 0; a tracked position output; glitch-free period updates; a step mode that issues exactly N edges and then reports done.
- Sits between the PS-side config registers (AXI-lite regs) and the encoder output pins.

Parameters:
- PERIOD_W, 29, width of edge-interval period.
- POS_W, 24, width of position and counts-per-revolution.
- STEP_W, 32, width of step count.
- Z_WIDTH, 50, Z pulse length in clk cycles (500 ns at 100 MHz); must be >= 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- mode  in  2  00 stop, 01 continuous, 10 step, 11 reserved (acts as stop).
- dir  in  1  0 increment (A leads B), 1 decrement.
- period  in  PERIOD_W  edge interval = period+1 cycles.
- cpr  in  POS_W  counts per revolution; 0 = free-run, no auto Z.
- step_cnt  in  STEP_W  edges to issue in step mode.
- start  in  1  one-cycle pulse, arms step mode.
- z_force  in  1  rising edge issues a manual Z pulse.
- pos_load  in  1  load position from pos_value.
- pos_value  in  POS_W  preset value.
- rot_a, rot_b, rot_z  out  1 each  encoder outputs, registered.
- position  out  POS_W  current count.
- busy  out  1  step sequence in progress.
- done  out  1  one-cycle pulse at step completion.

Behaviour:
- Reset (rstn=0 at a clk edge): phase 00 (a=0, b=0); position 0; rot_z 0; busy 0; done 0; all counters 0; z_force history 0.
- Moving = (mode==01) or (mode==10 and busy).
- Tick counter:
  - Held at 0 when not moving.
  - When moving, counts 0..per_act, then ticks and reloads 0.
  - per_act latches period at reset, while not moving, and on each tick. A period change never truncates the interval in flight.
  - period=0 gives a tick every cycle.
- Edge on tick:
  - {a,b} Gray sequence 00->10->11->01->00 for dir=0; reversed for dir=1.
  - Outputs change on the cycle after the tick (one register stage).
  - First edge occurs period+1 cycles after moving asserts.
- Position per edge:
  - dir=0: pos==cpr-1 ? 0 : pos+1.
  - dir=1: pos==0 ? cpr-1 : pos-1.
  - cpr=0: modulo 2^POS_W.
  - pos_load overrides any same-cycle edge update; it does not alter phase and does not trigger Z.
- Z pulse:
  - Auto trigger when an edge makes position 0 (either dir, cpr!=0). Also triggered by a z_force rising edge.
  - rot_z high exactly Z_WIDTH cycles, starting the cycle after the trigger.
  - A trigger while rot_z is high restarts the count (pulse extended); simultaneous auto and force = one pulse.
- Step mode:
  - start with mode==10 and busy=0: remaining <= step_cnt, busy <= 1.
  - If step_cnt==0: busy stays 0 and done pulses the next cycle.
  - Each edge decrements remaining. The edge taking it to 0 drops busy the same cycle as that output change; done pulses that cycle.
  - start while busy or mode!=10: ignored.
  - mode leaving 10 while busy: abort; busy 0, no done, remaining cleared, outputs hold.
- dir change mid-interval: applies to the next edge; no extra edge.
- Reset mid-operation: all state to reset values on that edge; in-flight Z and step are discarded.

Decomposition:
- Package quad_enc_pkg:
  - Mode localparams: MODE_STOP, MODE_CONT, MODE_STEP, MODE_RSVD.
  - Gray phase table and next/previous phase functions.
- One sub-module, quad_enc_tick:
  - Period latch and interval counter.
  - Inputs clk, rstn, run, period; output tick.
- The top holds phase, position, Z, and step logic.

Test Plan:
- Continuous: period=3, dir=0, cpr=8, mode=01 -> edges every 4 cycles, a/b sequence 00,10,11,01. Position 1..7 then 0; rot_z high 50 cycles starting the cycle after the position-0 edge.
- Decrement wrap: pos_load pos_value=0, dir=1, cpr=8 -> position 7,6,..., order 00,01,11,10. Z pulse on reaching 0 after 8 edges.
- Step: mode=10, step_cnt=5, period=1, start -> exactly 5 edges 2 cycles apart, busy high throughout, done one cycle coincident with the 5th edge. Second start with step_cnt=0 -> done next cycle, no edges.
- Period change: period 9->2 at cycle 4 of an interval -> current interval still 10 cycles, subsequent intervals 3.
- Z retrigger: z_force rising at t0 and again at t0+20 -> rot_z high continuously from t0+1 to t0+70.
- Reset mid-step: rstn=0 for one cycle while busy with 3 edges remaining -> a=b=0, position 0, busy 0, no done, rot_z 0.

Source files
------------

// File: rtl/quad_enc_pkg.sv
// quad_enc_pkg: shared definitions for the quadrature encoder emulator.
//   - mode encodings driven by the PS-side config registers
//   - {a,b} Gray phase type and the forward/backward phase step functions
package quad_enc_pkg;

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_CONT = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;  // behaves as stop

    // Encoder phase packed as {a, b}.
    typedef logic [1:0] phase_t;

    localparam phase_t PHASE_RESET = 2'b00;

    // Increment order (A leads B): 00 -> 10 -> 11 -> 01 -> 00.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Decrement order: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic phase_t prev_phase(input phase_t p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic phase_t step_phase(input phase_t p, input logic dir);
        return dir ? prev_phase(p) : next_phase(p);
    endfunction

endpackage

// File: rtl/quad_enc_tick.sv
// quad_enc_tick: edge-interval timer.
//   clk    in  clock
//   rstn   in  synchronous active-low reset
//   run    in  count while high; counter held at 0 while low
//   period in  interval length minus one (PERIOD_W bits)
//   tick   out one-cycle strobe at the end of each interval
// The active period is captured only while idle and at each tick, so a new
// period value never shortens or stretches the interval already running.
module quad_enc_tick #(
    parameter int PERIOD_W = 29
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] per_act;
    logic [PERIOD_W-1:0] cnt;

    assign tick = run && (cnt == per_act);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt     <= '0;
            per_act <= period;
        end else if (!run || tick) begin
            cnt     <= '0;
            per_act <= period;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/quad_enc_gen.sv
// quad_enc_gen: quadrature encoder emulator (A/B/Z) with position tracking.
//   clk, rstn          clock, synchronous active-low reset
//   mode               00 stop, 01 continuous, 10 step, 11 stop
//   dir                0 increment (A leads B), 1 decrement
//   period             edge interval = period+1 cycles
//   cpr                counts per revolution; 0 = free-run without auto Z
//   step_cnt, start    step mode edge count and arming pulse
//   z_force            rising edge issues a manual Z pulse
//   pos_load/pos_value position preset
//   rot_a/rot_b/rot_z  registered encoder outputs
//   position           current count
//   busy, done         step sequence in progress / completion pulse
module quad_enc_gen
    import quad_enc_pkg::*;
#(
    parameter int PERIOD_W = 29,
    parameter int POS_W    = 24,
    parameter int STEP_W   = 32,
    parameter int Z_WIDTH  = 50
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          mode,
    input  logic                dir,
    input  logic [PERIOD_W-1:0] period,
    input  logic [POS_W-1:0]    cpr,
    input  logic [STEP_W-1:0]   step_cnt,
    input  logic                start,
    input  logic                z_force,
    input  logic                pos_load,
    input  logic [POS_W-1:0]    pos_value,
    output logic                rot_a,
    output logic                rot_b,
    output logic                rot_z,
    output logic [POS_W-1:0]    position,
    output logic                busy,
    output logic                done
);

    localparam int ZC_W = (Z_WIDTH > 1) ? $clog2(Z_WIDTH) : 1;

    logic              moving;
    logic              tick;
    phase_t            phase;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  pos_edge;
    logic              z_force_d;
    logic              z_trig;
    logic [ZC_W-1:0]   z_cnt;
    logic [STEP_W-1:0] remaining;

    assign moving = (mode == MODE_CONT) || ((mode == MODE_STEP) && busy);

    quad_enc_tick #(.PERIOD_W(PERIOD_W)) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .run    (moving),
        .period (period),
        .tick   (tick)
    );

    // Position the next edge would produce, wrapping at the revolution size.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pos_edge = pos;
        if (!dir) begin
            pos_edge = (cpr != '0 && pos == cpr - 1'b1) ? '0 : pos + 1'b1;
        end else begin
            pos_edge = (cpr != '0 && pos == '0) ? cpr - 1'b1 : pos - 1'b1;
        end
    end

    // Auto Z only when the edge itself lands on 0; a same-cycle preset wins.
    assign z_trig = (tick && !pos_load && cpr != '0 && pos_edge == '0)
                 || (z_force && !z_force_d);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase     <= PHASE_RESET;
            pos       <= '0;
            z_force_d <= 1'b0;
            z_cnt     <= '0;
            rot_z     <= 1'b0;
        end else begin
            z_force_d <= z_force;
            if (tick) begin
                phase <= step_phase(phase, dir);
            end
            if (pos_load) begin
                pos <= pos_value;
            end else if (tick) begin
                pos <= pos_edge;
            end
            // rot_z stays high for Z_WIDTH cycles; a new trigger restarts it.
            if (z_trig) begin
                rot_z <= 1'b1;
                z_cnt <= ZC_W'(Z_WIDTH - 1);
            end else if (z_cnt != '0) begin
                z_cnt <= z_cnt - 1'b1;
            end else begin
                rot_z <= 1'b0;
            end
        end
    end

    // Step sequencer: arm, count edges down, finish or abort.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy      <= 1'b0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && mode != MODE_STEP) begin
                busy      <= 1'b0;
                remaining <= '0;
            end else if (busy && tick) begin
                remaining <= remaining - 1'b1;
                // Last edge: busy falls together with the output change.
                if (remaining == STEP_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (!busy && start && mode == MODE_STEP) begin
                if (step_cnt == '0) begin
                    done <= 1'b1;
                end else begin
                    remaining <= step_cnt;
                    busy      <= 1'b1;
                end
            end
        end
    end

    assign rot_a    = phase[1];
    assign rot_b    = phase[0];
    assign position = pos;

endmodule

// File: tb/tb_quad_enc_gen.sv
// tb_quad_enc_gen: self-checking bench for quad_enc_gen.
// A behavioural reference model (edge numbers, interval deadlines, Z end
// times) is advanced once per clock and compared with every DUT output one
// time unit after each rising edge; directed scenarios add timing checks.
module tb_quad_enc_gen;

    localparam int PERIOD_W = 29;
    localparam int POS_W    = 24;
    localparam int STEP_W   = 32;
    localparam int Z_WIDTH  = 50;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [1:0]          mode = 2'b00;
    logic                dir = 1'b0;
    logic [PERIOD_W-1:0] period = '0;
    logic [POS_W-1:0]    cpr = '0;
    logic [STEP_W-1:0]   step_cnt = '0;
    logic                start = 1'b0;
    logic                z_force = 1'b0;
    logic                pos_load = 1'b0;
    logic [POS_W-1:0]    pos_value = '0;
    logic                rot_a, rot_b, rot_z, busy, done;
    logic [POS_W-1:0]    position;

    quad_enc_gen #(
        .PERIOD_W(PERIOD_W), .POS_W(POS_W), .STEP_W(STEP_W), .Z_WIDTH(Z_WIDTH)
    ) dut (
        .clk(clk), .rstn(rstn), .mode(mode), .dir(dir), .period(period),
        .cpr(cpr), .step_cnt(step_cnt), .start(start), .z_force(z_force),
        .pos_load(pos_load), .pos_value(pos_value), .rot_a(rot_a),
        .rot_b(rot_b), .rot_z(rot_z), .position(position), .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]       ab_tab [4];
    longint           cyc = 0;        // number of clock edges seen
    longint           m_start = 1;    // edge number where the current interval began
    longint           m_len = 0;      // latched interval length minus one
    int               m_idx = 0;      // index into ab_tab
    logic [POS_W-1:0] m_pos = '0;
    longint           m_z_until = -1; // last edge number whose sample shows Z high
    logic             m_zf_prev = 1'b0;
    logic             m_busy = 1'b0;
    longint           m_rem = 0;
    logic             m_done = 1'b0;

    task automatic model_edge();
        logic moving, is_tick, z_trig, b0;
        logic [POS_W-1:0] np;
        cyc++;
        if (!rstn) begin
            m_start = cyc + 1; m_len = longint'(period);
            m_idx = 0; m_pos = '0; m_z_until = -1; m_zf_prev = 1'b0;
            m_busy = 1'b0; m_rem = 0; m_done = 1'b0;
            return;
        end
        b0 = m_busy;
        moving = (mode == 2'b01) || (mode == 2'b10 && b0);
        is_tick = 1'b0;
        if (!moving) begin
            m_start = cyc + 1; m_len = longint'(period);
        end else if (cyc - m_start == m_len) begin
            is_tick = 1'b1; m_start = cyc + 1; m_len = longint'(period);
        end
        z_trig = z_force && !m_zf_prev;
        m_zf_prev = z_force;
        if (is_tick) begin
            m_idx = (m_idx + (dir ? 3 : 1)) % 4;
            if (!dir) np = (cpr != '0 && m_pos == cpr - 1'b1) ? '0 : m_pos + 1'b1;
            else      np = (cpr != '0 && m_pos == '0) ? cpr - 1'b1 : m_pos - 1'b1;
            if (!pos_load) begin
                m_pos = np;
                if (cpr != '0 && np == '0) z_trig = 1'b1;
            end
        end
        if (pos_load) m_pos = pos_value;
        if (z_trig) m_z_until = cyc + Z_WIDTH - 1;
        m_done = 1'b0;
        if (b0 && mode != 2'b10) begin
            m_busy = 1'b0; m_rem = 0;
        end else if (b0 && is_tick) begin
            m_rem--;
            if (m_rem == 0) begin m_busy = 1'b0; m_done = 1'b1; end
        end else if (!b0 && start && mode == 2'b10) begin
            if (step_cnt == '0) m_done = 1'b1;
            else begin m_rem = longint'(step_cnt); m_busy = 1'b1; end
        end
    endtask

    task automatic compare_all();
        check("rot_a", rot_a, ab_tab[m_idx][1]);
        check("rot_b", rot_b, ab_tab[m_idx][0]);
        check("rot_z", rot_z, cyc <= m_z_until);
        check("position", position, m_pos);
        check("busy", busy, m_busy);
        check("done", done, m_done);
    endtask

    // ---------------- DUT activity trackers ----------------
    logic [1:0] prev_ab = 2'b00;
    logic       prev_z = 1'b0;
    logic       last_edge = 1'b0;
    int         edges = 0, done_cnt = 0, z_high = 0, z_rises = 0;

    task automatic clear_counts();
        edges = 0; done_cnt = 0; z_high = 0; z_rises = 0;
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
        last_edge = ({rot_a, rot_b} != prev_ab);
        if (last_edge) edges++;
        prev_ab = {rot_a, rot_b};
        if (done === 1'b1) done_cnt++;
        if (rot_z === 1'b1) z_high++;
        if (rot_z === 1'b1 && prev_z !== 1'b1) z_rises++;
        prev_z = rot_z;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) clk_step();
    endtask

    int edge_at[$];
    int waited;

    initial begin
        ab_tab[0] = 2'b00; ab_tab[1] = 2'b10; ab_tab[2] = 2'b11; ab_tab[3] = 2'b01;

        // Reset state
        run_steps(2);
        check("rst_a", rot_a, 1'b0);
        check("rst_b", rot_b, 1'b0);
        check("rst_z", rot_z, 1'b0);
        check("rst_pos", position, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rstn = 1'b1;
        run_steps(2);

        // Continuous increment, cpr=8: 8 edges, position back to 0, Z 50 cycles
        period = 3; cpr = 8; dir = 1'b0;
        clk_step();
        clear_counts();
        mode = 2'b01;
        run_steps(33);
        check("cont_edges", edges, 8);
        check("cont_pos0", position, 0);
        check("cont_z_on", rot_z, 1'b1);
        mode = 2'b00;
        run_steps(60);
        check("cont_z_len", z_high, Z_WIDTH);

        // Decrement wrap from 0
        pos_load = 1'b1; pos_value = '0; dir = 1'b1;
        clk_step();
        pos_load = 1'b0;
        clear_counts();
        mode = 2'b01;
        clk_step();
        check("dec_pos7", position, 0);
        run_steps(3);
        check("dec_first", position, 7);
        check("dec_ab", {rot_a, rot_b}, 2'b01);
        run_steps(28);
        check("dec_edges", edges, 8);
        check("dec_pos0", position, 0);
        check("dec_z_on", rot_z, 1'b1);
        mode = 2'b00;
        run_steps(55);

        // Step mode: 5 edges, one done
        dir = 1'b0; period = 1; step_cnt = 5; mode = 2'b10; start = 1'b1;
        clear_counts();
        clk_step();
        start = 1'b0;
        check("step_busy", busy, 1'b1);
        run_steps(20);
        check("step_edges", edges, 5);
        check("step_done", done_cnt, 1);
        check("step_idle", busy, 1'b0);

        // Step with zero count: done next cycle, no edges
        step_cnt = 0; start = 1'b1;
        clear_counts();
        clk_step();
        start = 1'b0;
        check("step0_done", done, 1'b1);
        check("step0_busy", busy, 1'b0);
        run_steps(6);
        check("step0_edges", edges, 0);
        check("step0_done_cnt", done_cnt, 1);

        // Period change mid-interval: 10 then 3
        mode = 2'b00; period = 9; cpr = 0;
        clk_step();
        mode = 2'b01;
        edge_at.delete();
        for (int k = 1; k <= 30; k++) begin
            clk_step();
            if (last_edge) edge_at.push_back(k);
            if (k == 14) period = 2;
        end
        mode = 2'b00;
        check("per_nedges", edge_at.size() >= 4, 1'b1);
        if (edge_at.size() >= 4) begin
            check("per_first", edge_at[0], 10);
            check("per_inflight", edge_at[1] - edge_at[0], 10);
            check("per_new1", edge_at[2] - edge_at[1], 3);
            check("per_new2", edge_at[3] - edge_at[2], 3);
        end
        run_steps(3);

        // Z retrigger: force at t0 and t0+20 -> 70 contiguous cycles
        clear_counts();
        z_force = 1'b1;
        clk_step();
        z_force = 1'b0;
        run_steps(19);
        z_force = 1'b1;
        clk_step();
        z_force = 1'b0;
        run_steps(79);
        check("zre_len", z_high, 70);
        check("zre_rises", z_rises, 1);

        // Reset in the middle of a step sequence
        period = 3; cpr = 4; pos_load = 1'b1; pos_value = '0;
        clk_step();
        pos_load = 1'b0;
        clear_counts();
        mode = 2'b10; step_cnt = 6; start = 1'b1; z_force = 1'b1;
        clk_step();
        start = 1'b0; z_force = 1'b0;
        waited = 0;
        while (edges < 3 && waited < 100) begin
            clk_step();
            waited++;
        end
        check("rs_wait_edges", edges, 3);
        check("rs_busy_before", busy, 1'b1);
        rstn = 1'b0;
        clk_step();
        check("rs_a", rot_a, 1'b0);
        check("rs_b", rot_b, 1'b0);
        check("rs_pos", position, 0);
        check("rs_busy", busy, 1'b0);
        check("rs_z", rot_z, 1'b0);
        rstn = 1'b1;
        clear_counts();
        run_steps(30);
        check("rs_no_done", done_cnt, 0);
        check("rs_no_edges", edges, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 4) mode = 2'($urandom_range(3));
            if ($urandom_range(99) < 5) dir = 1'($urandom_range(1));
            if ($urandom_range(99) < 5) period = PERIOD_W'($urandom_range(4));
            if ($urandom_range(99) < 2) begin
                case ($urandom_range(3))
                    0: cpr = '0;
                    1: cpr = 1;
                    2: cpr = 5;
                    default: cpr = 8;
                endcase
            end
            step_cnt  = STEP_W'($urandom_range(6));
            start     = ($urandom_range(99) < 6);
            z_force   = ($urandom_range(99) < 3) ? ~z_force : z_force;
            pos_load  = ($urandom_range(99) < 2);
            pos_value = ($urandom_range(1) == 1) ? POS_W'($urandom_range(9)) : POS_W'($urandom);
            rstn      = ($urandom_range(999) >= 3);
            clk_step();
        end
        rstn = 1'b1; start = 1'b0; pos_load = 1'b0;
        run_steps(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
